// File: rtl/frame_scheduler_if.sv
// Downstream sample stream from frame_scheduler to the windowing/FFT stage.
// The master side drives data/valid/last/idx; the slave side drives ready.
interface frame_scheduler_if #(
  parameter int WIDTH      = 16,
  parameter int FRAME_SIZE = 306
);
  localparam int IDX_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;
  logic [IDX_W-1:0] idx;

  modport master (output data, output valid, output last, output idx, input ready);
  modport slave  (input data, input valid, input last, input idx, output ready);
endinterface

// File: rtl/frame_scheduler.sv
// Streams each complete frame out of the window buffer to the spectral stage,
// then commands the buffer to hop and counts finished frames.
module frame_scheduler #(
  parameter int WIDTH      = 16,
  parameter int FRAME_SIZE = 306,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  output logic                 wb_start_move_o,
  output logic                 wb_rd_en_o,
  input  logic [WIDTH-1:0]     wb_data_i,
  input  logic                 wb_valid_i,
  input  logic                 wb_next_state_i,
  input  logic                 wb_idle_i,
  frame_scheduler_if.master    out_if,
  output logic [CNT_W-1:0]     frame_cnt_o,
  output logic                 busy_o
);

  localparam int IDX_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int ISS_W = $clog2(FRAME_SIZE + 1);
  localparam logic [ISS_W-1:0] ISS_FULL = ISS_W'(FRAME_SIZE);
  localparam logic [ISS_W-1:0] ISS_LAST = ISS_W'(FRAME_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    WAIT_WB,
    MOVE,
    SETTLE
  } state_t;

  state_t            state_q;
  logic [ISS_W-1:0]  issuedCnt_q;
  logic              rdPrev_q;
  logic [WIDTH-1:0]  outData_q;
  logic              outValid_q;
  logic              outLast_q;
  logic [IDX_W-1:0]  outIdx_q;
  logic [CNT_W-1:0]  frameCnt_q;
  logic [CNT_W-1:0]  frameCnt_d;
  logic              startMove_q;
  logic              busy_q;
  logic              slotFree;
  logic              readIssue;

  // Reads are spaced at least two cycles apart so the buffer's registered
  // valid has caught up with its pointer before the next read is issued.
  assign slotFree   = !outValid_q || out_if.ready;
  assign readIssue  = (state_q == STREAM) && wb_valid_i && slotFree &&
                      (issuedCnt_q < ISS_FULL) && !rdPrev_q;
  assign frameCnt_d = frameCnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issuedCnt_q <= '0;
      rdPrev_q    <= 1'b0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      outIdx_q    <= '0;
      frameCnt_q  <= '0;
      startMove_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rdPrev_q    <= readIssue;
      startMove_q <= 1'b0;

      if (readIssue) begin
        outData_q   <= wb_data_i;
        outValid_q  <= 1'b1;
        outIdx_q    <= issuedCnt_q[IDX_W-1:0];
        outLast_q   <= (issuedCnt_q == ISS_LAST);
        issuedCnt_q <= issuedCnt_q + ISS_W'(1);
      end else if (out_if.ready) begin
        outValid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q     <= STREAM;
            issuedCnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        STREAM: begin
          if (readIssue && (issuedCnt_q == ISS_LAST)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (outValid_q && out_if.ready) begin
            state_q    <= WAIT_WB;
            frameCnt_q <= frameCnt_d;
          end
        end
        // The hop is only commanded once the buffer reports idle.
        WAIT_WB: begin
          if (wb_idle_i) begin
            state_q     <= MOVE;
            startMove_q <= 1'b1;
          end
        end
        MOVE: begin
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (wb_next_state_i) begin
            if (enable_i) begin
              state_q     <= STREAM;
              issuedCnt_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_rd_en_o      = readIssue;
  assign wb_start_move_o = startMove_q;
  assign out_if.data     = outData_q;
  assign out_if.valid    = outValid_q;
  assign out_if.last     = outLast_q;
  assign out_if.idx      = outIdx_q;
  assign frame_cnt_o     = frameCnt_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: pre-filled window buffer model, scoreboard on the
// output stream, and a table of per-frame scenarios plus a reset sequence.
module tb_frame_scheduler;

  localparam int WIDTH      = 16;
  localparam int FRAME_SIZE = 306;
  localparam int CNT_W      = 2;
  localparam int HOP        = 123;
  localparam int IDX_W      = $clog2(FRAME_SIZE);
  localparam int LIMIT      = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic startMove, rdEn;
  logic wbValid, wbNextState, wbIdle;
  logic [WIDTH-1:0] wbData;
  logic [CNT_W-1:0] frameCnt;
  logic busy;

  int total = 0;
  int bad = 0;

  frame_scheduler_if #(.WIDTH(WIDTH), .FRAME_SIZE(FRAME_SIZE)) outIf ();

  frame_scheduler #(.WIDTH(WIDTH), .FRAME_SIZE(FRAME_SIZE), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable),
    .wb_start_move_o (startMove),
    .wb_rd_en_o      (rdEn),
    .wb_data_i       (wbData),
    .wb_valid_i      (wbValid),
    .wb_next_state_i (wbNextState),
    .wb_idle_i       (wbIdle),
    .out_if          (outIf),
    .frame_cnt_o     (frameCnt),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] sampleAt(input int unsigned k);
    return WIDTH'(k * 37 + 11);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Buffer model: always full, hop of HOP samples per start_move, idle drops
  // for a few cycles after a move and returns with a next_state pulse.
  int unsigned base = 0;
  int unsigned rdPtr = 0;
  int moveCount = 0;
  int nsCount = 0;
  int badMove = 0;
  int badRead = 0;
  int settleCnt = 0;
  logic holdValid = 1'b0;
  logic prevStartMove = 1'b0;

  assign wbData = sampleAt(base + rdPtr);

  always @(posedge clk) begin
    if (rst) begin
      rdPtr         <= 0;
      base          <= 0;
      wbValid       <= 1'b0;
      wbIdle        <= 1'b1;
      wbNextState   <= 1'b0;
      settleCnt     <= 0;
      prevStartMove <= 1'b0;
    end else begin
      prevStartMove <= startMove;
      wbValid       <= !holdValid;
      wbNextState   <= 1'b0;
      if (rdEn) rdPtr <= rdPtr + 1;
      if (startMove) begin
        moveCount <= moveCount + 1;
        if (!wbIdle || prevStartMove) badMove <= badMove + 1;
        base      <= base + HOP;
        rdPtr     <= 0;
        wbIdle    <= 1'b0;
        settleCnt <= 3;
      end else if (settleCnt > 0) begin
        settleCnt <= settleCnt - 1;
        if (settleCnt == 1) begin
          wbNextState <= 1'b1;
          wbIdle      <= 1'b1;
          nsCount     <= nsCount + 1;
        end
      end
    end
  end

  logic randReady = 1'b0;
  initial begin
    outIf.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      outIf.ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard: every accepted sample must be the next buffer sample in order.
  int expIdx = 0;
  int unsigned expBase = 0;
  int rxFrames = 0;
  int cyc = 0;
  int rdSeen = 0;
  int firstRdCyc = 0;
  int lastSpan = -1;
  logic heldValid = 1'b0;
  logic [WIDTH-1:0] heldData = '0;
  logic [IDX_W-1:0] heldIdx = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        expIdx    = 0;
        expBase   = 0;
        heldValid = 1'b0;
        rdSeen    = 0;
      end else begin
        if (heldValid && outIf.valid) begin
          checkOutput("hold data", 32'(outIf.data), 32'(heldData));
          checkOutput("hold idx", 32'(outIf.idx), 32'(heldIdx));
        end
        if (outIf.valid && outIf.ready) begin
          checkOutput("data", 32'(outIf.data), 32'(sampleAt(expBase + expIdx)));
          checkOutput("idx", 32'(outIf.idx), 32'(expIdx));
          checkOutput("last", 32'(outIf.last), 32'(expIdx == FRAME_SIZE - 1));
          expIdx++;
          if (expIdx == FRAME_SIZE) begin
            expIdx  = 0;
            expBase = expBase + HOP;
            rxFrames++;
          end
        end
        heldValid = outIf.valid && !outIf.ready;
        heldData  = outIf.data;
        heldIdx   = outIf.idx;
        if (rdEn) begin
          if (rdSeen % FRAME_SIZE == 0) firstRdCyc = cyc;
          if (rdSeen % FRAME_SIZE == FRAME_SIZE - 1) lastSpan = cyc - firstRdCyc;
          rdSeen++;
          if (!wbValid) badRead++;
        end
      end
    end
  end

  typedef struct {
    string name;
    bit    randReady;
    int    stallAt;
    int    dropAt;
    int    expCnt;
    bit    expBusy;
    int    expSpan;
  } vec_t;

  vec_t vecs[6];

  task automatic waitIdx(input string name, input int idx);
    for (int c = 0; c < LIMIT && expIdx < idx; c++) begin
      @(negedge clk);
      #1;
    end
    checkOutput({name, " reach idx timeout"}, 32'(expIdx >= idx), 32'd1);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " start_move"}, 32'(startMove), 32'd0);
    checkOutput({name, " rd_en"}, 32'(rdEn), 32'd0);
    checkOutput({name, " valid"}, 32'(outIf.valid), 32'd0);
    checkOutput({name, " last"}, 32'(outIf.last), 32'd0);
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " data"}, 32'(outIf.data), 32'd0);
    checkOutput({name, " idx"}, 32'(outIf.idx), 32'd0);
    checkOutput({name, " frame_cnt"}, 32'(frameCnt), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int targetFrames;
    int targetMoves;
    targetFrames = rxFrames + 1;
    targetMoves  = moveCount + 1;
    enable    = 1'b1;
    randReady = v.randReady;
    if (v.stallAt >= 0) begin
      waitIdx(v.name, v.stallAt);
      holdValid = 1'b1;
      repeat (20) begin
        @(negedge clk);
        checkOutput({v.name, " rd_en during stall"}, 32'(rdEn), 32'd0);
      end
      holdValid = 1'b0;
    end
    if (v.dropAt >= 0) begin
      waitIdx(v.name, v.dropAt);
      enable = 1'b0;
    end
    for (int c = 0; c < LIMIT && rxFrames < targetFrames; c++) @(negedge clk);
    checkOutput({v.name, " frame timeout"}, 32'(rxFrames >= targetFrames), 32'd1);
    for (int c = 0; c < LIMIT && nsCount < targetMoves; c++) @(negedge clk);
    checkOutput({v.name, " hop timeout"}, 32'(nsCount >= targetMoves), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput({v.name, " frame_cnt"}, 32'(frameCnt), 32'(v.expCnt));
    checkOutput({v.name, " busy"}, 32'(busy), 32'(v.expBusy));
    checkOutput({v.name, " moves"}, 32'(moveCount), 32'(targetMoves));
    checkOutput({v.name, " bad moves"}, 32'(badMove), 32'd0);
    checkOutput({v.name, " bad reads"}, 32'(badRead), 32'd0);
    if (v.expSpan >= 0) checkOutput({v.name, " stream span"}, 32'(lastSpan), 32'(v.expSpan));
    if (!v.expBusy) begin
      checkOutput({v.name, " idle rd_en"}, 32'(rdEn), 32'd0);
      checkOutput({v.name, " idle start_move"}, 32'(startMove), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"full ready", 1'b0, -1, -1, 1, 1'b1, 2 * FRAME_SIZE - 2};
    vecs[1] = '{"random ready 1", 1'b1, -1, -1, 2, 1'b1, -1};
    vecs[2] = '{"random ready 2", 1'b1, -1, -1, 3, 1'b1, -1};
    vecs[3] = '{"random ready 3 wrap", 1'b1, -1, -1, 0, 1'b1, -1};
    vecs[4] = '{"valid stall", 1'b0, 150, -1, 1, 1'b1, -1};
    vecs[5] = '{"enable drop", 1'b0, -1, 100, 2, 1'b0, -1};

    $display("[TB] reset and first read latency");
    repeat (3) @(negedge clk);
    checkResetState("reset");
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("first STREAM cycle rd_en", 32'(rdEn), 32'd1);
    checkOutput("busy after enable", 32'(busy), 32'd1);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] scenario %s", vecs[i].name);
      applyStimulus(vecs[i]);
    end

    $display("[TB] reset during STREAM");
    enable    = 1'b1;
    randReady = 1'b0;
    waitIdx("reset mid-frame", 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("mid-frame reset");
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus('{"after reset", 1'b0, -1, -1, 1, 1'b1, 2 * FRAME_SIZE - 2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
